// File: rtl/seqgen_pkg.sv
// Shared types and constants for the serial test-pattern transmitter.
package seqgen_pkg;

  // Transmitter FSM: waiting, shifting pattern bits, or sending idle-0 gap bits.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // What the seven-segment display should show.
  typedef enum logic [1:0] {
    DISP_DASH  = 2'd0,
    DISP_CONT  = 2'd1,
    DISP_DIGIT = 2'd2
  } disp_mode_t;

  // Active-high segment codes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_C    = 7'h39;

  // Digit table 0..7; element 0 is the rightmost entry.
  localparam logic [7:0][6:0] SEG_DIGITS = {
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  // Bit positions inside uio_out.
  localparam int UIO_SERIAL     = 0;
  localparam int UIO_BIT_VALID  = 1;
  localparam int UIO_BUSY       = 2;
  localparam int UIO_FRAME_DONE = 3;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational seven-segment encoder: dash, 'C' or a digit 0..7.
module seg7_encoder
  import seqgen_pkg::*;
(
  input  logic [2:0] digit,
  input  disp_mode_t mode,
  output logic [6:0] segments
);

  // Select the glyph for the requested display mode.
  always_comb begin
    segments = SEG_DASH;
    unique case (mode)
      DISP_DASH:  segments = SEG_DASH;
      DISP_CONT:  segments = SEG_C;
      DISP_DIGIT: segments = SEG_DIGITS[digit];
      default:    segments = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/tt_um_3515_sequence_generator.sv
// Serial test-pattern transmitter: sends PATTERN framed by idle-0 gap bits,
// repeated N times or continuously, with a frames-remaining display.
module tt_um_3515_sequence_generator
  import seqgen_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 1,
  parameter int         PAT_LEN      = 3,
  parameter logic [7:0] PATTERN      = 8'b0000_0100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2((PAT_LEN > 8) ? PAT_LEN : 8);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_FIRST = BIT_W'(PAT_LEN - 1);
  localparam bit ONE_CLK = (CLKS_PER_BIT == 1);

  logic              sync1, sync2, sync3;
  logic              start_pulse;
  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [2:0]        gap_cnt;
  logic [2:0]        gap_len;
  logic [2:0]        remaining;
  logic              cont_lat;
  logic              serial;
  logic              bit_valid;
  logic              busy;
  logic              frame_done;

  logic              bit_end;
  logic              start_go;
  logic              frame_end;
  logic              go_again;
  logic              busy_nxt;
  logic              cont_nxt;
  logic [2:0]        remaining_nxt;
  logic [2:0]        gap_sel;
  disp_mode_t        disp_mode;
  logic [6:0]        seg_nxt;

  assign uio_oe = 8'h0F;

  always_comb begin
    uio_out                 = 8'h00;
    uio_out[UIO_SERIAL]     = serial;
    uio_out[UIO_BIT_VALID]  = bit_valid;
    uio_out[UIO_BUSY]       = busy;
    uio_out[UIO_FRAME_DONE] = frame_done;
  end

  // Two-flop synchronizer on the start request plus a third flop for edge detect.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= ui_in[0];
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign start_pulse = sync2 & ~sync3;

  // Frame-boundary decisions shared by the FSM and the display look-ahead.
  always_comb begin
    bit_end   = (baud_cnt == BAUD_LAST);
    start_go  = (state == IDLE) && start_pulse;
    frame_end = (state == GAP) && bit_end && (gap_cnt == 3'd0);
    go_again  = cont_lat ? ui_in[1] : (remaining != 3'd0);
    gap_sel   = (ui_in[4:2] == 3'd0) ? 3'd1 : ui_in[4:2];

    busy_nxt      = (state != IDLE);
    cont_nxt      = cont_lat;
    remaining_nxt = remaining;
    if (start_go) begin
      busy_nxt      = 1'b1;
      cont_nxt      = ui_in[1];
      remaining_nxt = ui_in[7:5];
    end else if (frame_end) begin
      busy_nxt = go_again;
      if (!cont_lat && remaining != 3'd0) begin
        remaining_nxt = remaining - 3'd1;
      end
    end

    if (!busy_nxt) begin
      disp_mode = DISP_DASH;
    end else if (cont_nxt) begin
      disp_mode = DISP_CONT;
    end else begin
      disp_mode = DISP_DIGIT;
    end
  end

  seg7_encoder u_seg7 (
    .digit    (remaining_nxt),
    .mode     (disp_mode),
    .segments (seg_nxt)
  );

  // Transmitter FSM with registered serial, strobe, busy and display outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= 3'd0;
      gap_len    <= 3'd0;
      remaining  <= 3'd0;
      cont_lat   <= 1'b0;
      serial     <= 1'b0;
      bit_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      uo_out     <= {1'b0, SEG_DASH};
    end else begin
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= busy_nxt;
      remaining  <= remaining_nxt;
      cont_lat   <= cont_nxt;
      uo_out     <= {busy_nxt, seg_nxt};

      unique case (state)
        IDLE: begin
          serial <= 1'b0;
          if (start_pulse) begin
            gap_len   <= gap_sel;
            state     <= SEND;
            baud_cnt  <= '0;
            bit_cnt   <= BIT_FIRST;
            serial    <= PATTERN[BIT_FIRST];
            bit_valid <= 1'b1;
          end
        end

        SEND: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            bit_valid <= 1'b1;
            if (bit_cnt == '0) begin
              state      <= GAP;
              gap_cnt    <= gap_len - 3'd1;
              serial     <= 1'b0;
              frame_done <= ONE_CLK && (gap_len == 3'd1);
            end else begin
              bit_cnt <= bit_cnt - BIT_W'(1);
              serial  <= PATTERN[bit_cnt - BIT_W'(1)];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        GAP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (gap_cnt == 3'd0) begin
              if (go_again) begin
                state     <= SEND;
                bit_cnt   <= BIT_FIRST;
                serial    <= PATTERN[BIT_FIRST];
                bit_valid <= 1'b1;
              end else begin
                state  <= IDLE;
                serial <= 1'b0;
              end
            end else begin
              gap_cnt    <= gap_cnt - 3'd1;
              bit_valid  <= 1'b1;
              frame_done <= ONE_CLK && (gap_cnt == 3'd1);
            end
          end else begin
            baud_cnt   <= baud_cnt + BAUD_W'(1);
            frame_done <= (baud_cnt + BAUD_W'(1) == BAUD_LAST) && (gap_cnt == 3'd0);
          end
        end

        default: begin
          state  <= IDLE;
          serial <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_3515_sequence_generator.sv
// Directed scoreboard bench for the serial test-pattern transmitter.
module tb_tt_um_3515_sequence_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] ui_in4;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uo_out4, uio_out4, uio_oe4;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [15:0] sb_q[$];
  string       tag_q[$];

  logic [1:0] hist;
  int         det_cnt;
  logic       det_clear = 1'b1;

  always #5 clk = ~clk;

  tt_um_3515_sequence_generator dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  tt_um_3515_sequence_generator #(.CLKS_PER_BIT(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in4),
    .uo_out  (uo_out4),
    .uio_out (uio_out4),
    .uio_oe  (uio_oe4)
  );

  // Reference "100" detector fed by the serial line, one sample per bit.
  always @(negedge clk) begin
    if (det_clear) begin
      hist    <= 2'b00;
      det_cnt <= 0;
    end else if (uio_out[1]) begin
      hist <= {hist[0], uio_out[0]};
      if ({hist, uio_out[0]} == 3'b100) det_cnt <= det_cnt + 1;
    end
  end

  function automatic logic [7:0] segDigit(input int d);
    case (d)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      default: return 8'h00;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic pushEntry(input string tag, input logic [7:0] uo, input logic [7:0] uio);
    sb_q.push_back({uo, uio});
    tag_q.push_back(tag);
  endtask

  // Expected per-cycle outputs for a run of "100" frames followed by idle cycles.
  task automatic pushFrames(input string tag, input int n, input bit cont, input int frames,
                            input int gap, input int clks, input int idle_n);
    logic [2:0] pat;
    logic [7:0] disp;
    pat = 3'b100;
    for (int f = 0; f < frames; f++) begin
      disp = cont ? 8'hB9 : (8'h80 | segDigit(n - f));
      for (int b = 2; b >= 0; b--)
        for (int c = 0; c < clks; c++)
          pushEntry(tag, disp, {4'b0000, 1'b0, 1'b1, (c == 0), pat[b]});
      for (int g = 0; g < gap; g++)
        for (int c = 0; c < clks; c++)
          pushEntry(tag, disp, {4'b0000, (g == gap - 1 && c == clks - 1), 1'b1, (c == 0), 1'b0});
    end
    for (int i = 0; i < idle_n; i++) pushEntry(tag, 8'h40, 8'h00);
  endtask

  // Drive a start word and wait until the first transmitted bit is visible.
  task automatic applyStimulus(input bit sel, input logic [7:0] value);
    @(negedge clk);
    if (sel) ui_in4 = value;
    else     ui_in  = value;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic releaseStart();
    ui_in  = 8'h00;
    ui_in4 = 8'h00;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic drainScoreboard(input bit sel, input int idx_a, input logic [7:0] val_a,
                                 input int idx_b, input logic [7:0] val_b);
    int          idx;
    logic [15:0] e;
    logic [15:0] obs;
    string       t;
    idx = 0;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      t   = tag_q.pop_front();
      obs = sel ? {uo_out4, uio_out4} : {uo_out, uio_out};
      checkOutput($sformatf("%s[%0d]", t, idx), obs, e);
      if (idx == idx_a) ui_in = val_a;
      if (idx == idx_b) ui_in = val_b;
      idx++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    ui_in  = 8'h00;
    ui_in4 = 8'h00;
    rst_n  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("reset_out", {uo_out, uio_out}, {8'h40, 8'h00});
    checkOutput("reset_oe", {8'h00, uio_oe}, 16'h000F);
    checkOutput("reset_out4", {uo_out4, uio_out4}, {8'h40, 8'h00});
    checkOutput("reset_oe4", {8'h00, uio_oe4}, 16'h000F);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] single frame, start held high");
    pushFrames("single", 0, 1'b0, 1, 1, 1, 16);
    applyStimulus(1'b0, 8'h01);
    drainScoreboard(1'b0, -1, 8'h00, -1, 8'h00);
    releaseStart();

    $display("[TB] repeat N=2 G=2 with extra start edge");
    pushFrames("repeat", 2, 1'b0, 3, 2, 1, 3);
    applyStimulus(1'b0, 8'h49);
    drainScoreboard(1'b0, 4, 8'h48, 7, 8'h49);
    releaseStart();

    $display("[TB] repeat N=7 G=7");
    pushFrames("max", 7, 1'b0, 8, 7, 1, 3);
    applyStimulus(1'b0, 8'hFD);
    drainScoreboard(1'b0, -1, 8'h00, -1, 8'h00);
    releaseStart();

    $display("[TB] continuous mode, dropped mid-pattern");
    det_clear = 1'b0;
    pushFrames("cont", 0, 1'b1, 3, 1, 1, 3);
    applyStimulus(1'b0, 8'h03);
    drainScoreboard(1'b0, 9, 8'h01, -1, 8'h00);
    checkOutput("detections", 16'(det_cnt), 16'd3);
    det_clear = 1'b1;
    releaseStart();

    $display("[TB] reset mid-frame");
    applyStimulus(1'b0, 8'h01);
    checkOutput("rst_bit0", {uo_out, uio_out}, {8'hBF, 8'h07});
    @(posedge clk);
    #1;
    checkOutput("rst_bit1", {uo_out, uio_out}, {8'hBF, 8'h06});
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_async", {uo_out, uio_out}, {8'h40, 8'h00});
    ui_in = 8'h00;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_hold", {uo_out, uio_out}, {8'h40, 8'h00});
    end
    @(negedge clk);
    rst_n = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checkOutput("rst_after", {uo_out, uio_out}, {8'h40, 8'h00});
    end
    pushFrames("post_rst", 0, 1'b0, 1, 1, 1, 2);
    applyStimulus(1'b0, 8'h01);
    drainScoreboard(1'b0, -1, 8'h00, -1, 8'h00);
    releaseStart();

    $display("[TB] CLKS_PER_BIT=4 single frame");
    pushFrames("baud4", 0, 1'b0, 1, 1, 4, 3);
    applyStimulus(1'b1, 8'h01);
    drainScoreboard(1'b1, -1, 8'h00, -1, 8'h00);
    releaseStart();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tt_um_3515_sequence_generator.md
# tt_um_3515_sequence_generator

Serial test-pattern transmitter, the transmit side of the team's serial sequence detector. On a start request it emits a programmable bit pattern (default "100") as NRZ serial data, framed by idle-0 gap bits and repeated a programmable number of times or continuously. A seven-segment display shows the number of frames remaining. It is a standalone Tiny Tapeout user macro whose serial output drives a detector's `x` input directly.

## Interface
- `CLKS_PER_BIT`, default 1: clk cycles per serial bit (1..256).
- `PAT_LEN`, default 3: pattern length in bits (1..8).
- `PATTERN`, default 8'b0000_0100: pattern bits, sent MSB-first from bit `PAT_LEN-1` down to bit 0.
- `clk` input 1: clock; all logic on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-high (`rst_n`=1 resets).
- `ui_in` input 8:
  - [0] start request.
  - [1] continuous mode.
  - [4:2] gap G.
  - [7:5] repeat N.
- `uo_out` output 8: display segments, [6:0]={g,f,e,d,c,b,a}, [7]=dp; active-high.
- `uio_out` output 8:
  - [0] serial data.
  - [1] bit_valid.
  - [2] busy.
  - [3] frame_done.
  - [7:4] = 0.
- `uio_oe` output 8: constant 8'h0F.

## Operation
- Start detection: `ui_in[0]` passes through a 2-flop synchronizer, then a third flop for edge detection. start_pulse = s2 & ~s3, i.e. a rising edge only. A held-high start yields exactly one start.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - serial=0, busy=0, display '-' (8'h40).
  - On start_pulse:
    - Latch N, G and continuous.
    - remaining=N, gap_len=max(G,1).
    - Load the pattern MSB; go to SEND.
- Start requests in SEND or GAP are ignored.
- SEND: shifts out `PAT_LEN` bits, each held `CLKS_PER_BIT` cycles. After the last bit, go to GAP.
- GAP: drives gap_len zero bits.
  - The minimum of one 0 is mandatory: it lets the detector return to its initial state before the next frame's leading 1.
  - At the end of the last gap bit, frame_done pulses for 1 cycle, then:
    - If continuous mode is latched and live `ui_in[1]`=1, go to SEND.
    - Else if remaining>0, decrement remaining and go to SEND.
    - Else go to IDLE.
- Continuous mode: live `ui_in[1]` is checked only at frame boundaries. Dropping it mid-frame finishes the current frame and gap, then returns to IDLE. remaining is not decremented in continuous mode.
- bit_valid: 1-cycle pulse in the first clk cycle of every transmitted bit, pattern and gap alike.
- busy: 1 in SEND and GAP.
- Display:
  - IDLE: '-' (8'h40).
  - Busy, continuous: 'C' (8'h39) with dp=1.
  - Busy, otherwise: digit `remaining` (0..7), standard active-high codes (0=8'h3F … 7=8'h07) with dp=1.
- Reset values: uo_out=8'h40; uio_out=8'h00; all state, counters and synchronizer flops 0; FSM=IDLE. uio_oe is unaffected (constant).
- Reset mid-operation: outputs go to the reset values immediately (asynchronously). The partially sent frame is abandoned. The first start after reset release needs a fresh rising edge.

## Timing
- All outputs are registered.
- Start latency: let E0 be the first clk edge that samples `ui_in[0]`=1. After E2 the FSM is in SEND; serial, bit_valid and busy are valid from E2 onward.
- Frame length = (PAT_LEN + gap_len) × CLKS_PER_BIT cycles.
- Back-to-back frames have no dead cycle: the next frame's first pattern bit follows the last gap bit directly.
- busy falls at the clk edge ending the final gap bit, in the same cycle as frame_done deasserts.
- Bit counter width is clog2(max(PAT_LEN,8)). The baud counter counts 0..CLKS_PER_BIT-1 and wraps.
- `CLKS_PER_BIT`=1 makes bit_valid constantly 1 while busy.

## Structure
- Package `seqgen_pkg` holds:
  - the FSM state typedef (IDLE, SEND, GAP);
  - segment constants SEG_DASH, SEG_C and the digit table 0–7;
  - the output bit-index constants for uio_out.
- Sub-module `seg7_encoder`: 3-bit digit plus mode → 7 segments. It is combinational, and its output is registered in the top.
- Top contains the synchronizer, baud counter, bit/gap counters, repeat counter and FSM.

## Test plan
- Reset: hold rst_n=1 → uo_out=8'h40, uio_out=8'h00, uio_oe=8'h0F. Assert rst_n mid-clock → outputs change without a clk edge.
- Single frame (defaults, ui_in=8'h01):
  - serial = 1,0,0,0 on consecutive cycles from E2;
  - busy high 4 cycles;
  - frame_done on the 4th cycle;
  - display 0.+dp, then '-'.
- Repeat (ui_in=8'h49: N=2, G=2) → 3 frames of 1,0,0,0,0 (15 cycles), display 2→1→0, 3 frame_done pulses, then IDLE.
- Continuous (ui_in=8'h03):
  - display 'C', frames repeat;
  - clear `ui_in[1]` mid-pattern → current frame and gap complete, then IDLE;
  - reference-model detector sees one detection per frame.
- Start robustness:
  - start held high 20 cycles → exactly one frame;
  - second start edge during busy → ignored;
  - rst_n pulse after 2 bits → serial=0, busy=0 immediately, no frame_done.
- CLKS_PER_BIT=4 → each bit lasts 4 cycles, bit_valid every 4th cycle, single frame busy for 16 cycles.
